// File: rtl/chip_link_tx.sv
// Packet-to-flit serialiser for a chip-to-chip link: buffers whole packets and
// sends each one MSB-slice first over a 4-phase valid/ready handshake with parity and retry.
module chip_link_tx #(
  parameter int PKT_W          = 60,
  parameter int CHIPDATA_WIDTH = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_RETRY      = 3,
  parameter int PAR_ODD        = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PKT_W-1:0]                  pkt_data,
  input  logic                              pkt_valid,
  output logic                              pkt_ready,
  output logic [CHIPDATA_WIDTH-1:0]         send_data_out,
  output logic                              send_data_valid,
  output logic                              send_data_par,
  input  logic                              send_data_ready,
  input  logic                              send_data_err,
  output logic                              busy,
  output logic                              retry_fail,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int NF    = (PKT_W + CHIPDATA_WIDTH - 1) / CHIPDATA_WIDTH;
  localparam int FW    = NF * CHIPDATA_WIDTH;
  localparam int IDX_W = (NF > 1) ? $clog2(NF) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int RC_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NF - 1);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRY);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE, NEXT} state_t;

  logic [PKT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  state_t           state;
  logic [IDX_W-1:0] flit_idx;
  logic [RC_W-1:0]  retry_cnt;
  logic             err_q;
  logic             push, pop;

  // Flit 0 is the top slice of the packet zero-extended to a whole number of flits.
  function automatic logic [CHIPDATA_WIDTH-1:0] flit_of(input logic [PKT_W-1:0] pkt,
                                                        input logic [IDX_W-1:0] idx);
    logic [FW-1:0] padded;
    int            shamt;
    padded = FW'(pkt);
    shamt  = (NF - 1 - int'(idx)) * CHIPDATA_WIDTH;
    return CHIPDATA_WIDTH'(padded >> shamt);
  endfunction

  function automatic logic par_of(input logic [CHIPDATA_WIDTH-1:0] f);
    return (^f) ^ (PAR_ODD != 0);
  endfunction

  assign pkt_ready = (fifo_level < LVL_FULL);

  // The head packet stays buffered until its last flit or its retry budget is done.
  always_comb begin
    push = pkt_valid && pkt_ready;
    pop  = 1'b0;
    if (state == NEXT)
      pop = err_q ? (retry_cnt == RC_MAX) : (flit_idx == LAST_IDX);
  end

  // NOTE: packet storage has no reset; the pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt_data;
  end

  // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_level      <= '0;
      flit_idx        <= '0;
      retry_cnt       <= '0;
      err_q           <= 1'b0;
      send_data_out   <= '0;
      send_data_par   <= 1'b0;
      send_data_valid <= 1'b0;
      busy            <= 1'b0;
      retry_fail      <= 1'b0;
    end else begin
      retry_fail <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;

      case (state)
        IDLE: begin
          if (fifo_level != '0) begin
            flit_idx        <= '0;
            retry_cnt       <= '0;
            send_data_out   <= flit_of(mem[rd_ptr], '0);
            send_data_par   <= par_of(flit_of(mem[rd_ptr], '0));
            send_data_valid <= 1'b1;
            busy            <= 1'b1;
            state           <= DRIVE;
          end
        end
        DRIVE: begin
          if (send_data_ready) begin
            err_q           <= send_data_err;
            send_data_valid <= 1'b0;
            state           <= RELEASE;
          end
        end
        RELEASE: begin
          if (!send_data_ready) state <= NEXT;
        end
        NEXT: begin
          if (err_q && retry_cnt < RC_MAX) begin
            retry_cnt       <= retry_cnt + 1'b1;
            send_data_valid <= 1'b1;
            state           <= DRIVE;
          end else if (pop) begin
            retry_fail <= err_q;
            retry_cnt  <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            retry_cnt       <= '0;
            flit_idx        <= flit_idx + 1'b1;
            send_data_out   <= flit_of(mem[rd_ptr], flit_idx + 1'b1);
            send_data_par   <= par_of(flit_of(mem[rd_ptr], flit_idx + 1'b1));
            send_data_valid <= 1'b1;
            state           <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_link_tx.sv
// Directed bench for chip_link_tx: a default-parameter instance driven through the
// handshake, retry, backpressure and reset cases, plus a 32-bit odd-parity instance.
module tb_chip_link_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [59:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [15:0] send_data_out;
  logic        send_data_valid, send_data_par;
  logic        send_data_ready, send_data_err;
  logic        busy, retry_fail;
  logic [2:0]  fifo_level;

  logic [31:0] p32_data;
  logic        p32_valid, p32_ready;
  logic [15:0] s32_out;
  logic        s32_valid, s32_par, s32_ready, s32_err;
  logic        busy32, rf32;
  logic [2:0]  lvl32;

  int n_checks = 0;
  int n_fail   = 0;
  int rf_count = 0;
  int rf_base;

  localparam logic [59:0] PKT_A = 60'h123456789ABCDEF;  // 0123 4567 89AB CDEF
  localparam logic [59:0] PKT_B = 60'hFEDCBA987654321;  // 0FED CBA9 8765 4321

  chip_link_tx dut (
    .clk(clk), .rst(rst),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .send_data_out(send_data_out), .send_data_valid(send_data_valid),
    .send_data_par(send_data_par), .send_data_ready(send_data_ready),
    .send_data_err(send_data_err), .busy(busy), .retry_fail(retry_fail),
    .fifo_level(fifo_level)
  );

  chip_link_tx #(.PKT_W(32), .CHIPDATA_WIDTH(16), .PAR_ODD(1)) dut32 (
    .clk(clk), .rst(rst),
    .pkt_data(p32_data), .pkt_valid(p32_valid), .pkt_ready(p32_ready),
    .send_data_out(s32_out), .send_data_valid(s32_valid),
    .send_data_par(s32_par), .send_data_ready(s32_ready),
    .send_data_err(s32_err), .busy(busy32), .retry_fail(rf32),
    .fifo_level(lvl32)
  );

  always #5 clk = ~clk;

  // Number of sampled cycles with retry_fail high, used to measure the pulse width.
  always @(negedge clk) if (retry_fail === 1'b1) rf_count <= rf_count + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [59:0] d);
    int n = 0;
    while (pkt_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("push ready", pkt_ready, 1);
    pkt_data  = d;
    pkt_valid = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (send_data_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check({tag, " valid"}, send_data_valid, 1);
  endtask

  // One full 4-phase handshake, checking the flit and its stability through release.
  task automatic flit(input string tag, input logic [15:0] ed, input logic ep, input logic e);
    int n = 0;
    wait_valid(tag);
    check({tag, " data"}, send_data_out, ed);
    check({tag, " par"}, send_data_par, ep);
    check({tag, " busy"}, busy, 1);
    send_data_ready = 1'b1;
    send_data_err   = e;
    @(negedge clk);
    while (send_data_valid !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    check({tag, " release"}, send_data_valid, 0);
    check({tag, " hold"}, send_data_out, ed);
    send_data_ready = 1'b0;
    send_data_err   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pkt_data = '0; pkt_valid = 1'b0;
    send_data_ready = 1'b0; send_data_err = 1'b0;
    p32_data = '0; p32_valid = 1'b0; s32_ready = 1'b0; s32_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst valid", send_data_valid, 0);
    check("rst data", send_data_out, 0);
    check("rst par", send_data_par, 0);
    check("rst busy", busy, 0);
    check("rst retry_fail", retry_fail, 0);
    check("rst level", fifo_level, 0);
    check("rst pkt_ready", pkt_ready, 1);

    // Clean packet, latency and flit order
    push(PKT_A);
    check("lat level", fifo_level, 1);
    check("lat valid E0", send_data_valid, 0);
    @(negedge clk);
    check("lat valid E1", send_data_valid, 1);
    flit("t1 f0", 16'h0123, 1'b0, 1'b0);
    flit("t1 f1", 16'h4567, 1'b0, 1'b0);
    flit("t1 f2", 16'h89AB, 1'b0, 1'b0);
    flit("t1 f3", 16'hCDEF, 1'b0, 1'b0);
    @(negedge clk);
    check("t1 busy in next", busy, 1);
    @(negedge clk);
    check("t1 busy done", busy, 0);
    check("t1 level done", fifo_level, 0);

    // Single error on flit 1; err while ready=0 must be ignored
    rf_base = rf_count;
    push(PKT_A);
    wait_valid("t2 pre");
    send_data_err = 1'b1;
    repeat (3) @(negedge clk);
    check("t2 stall drive", send_data_valid, 1);
    send_data_err = 1'b0;
    flit("t2 f0", 16'h0123, 1'b0, 1'b0);
    flit("t2 f1", 16'h4567, 1'b0, 1'b1);
    flit("t2 f1 retry", 16'h4567, 1'b0, 1'b0);
    flit("t2 f2", 16'h89AB, 1'b0, 1'b0);
    flit("t2 f3", 16'hCDEF, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("t2 no retry_fail", rf_count - rf_base, 0);
    check("t2 idle", busy, 0);

    // Retry exhaustion on flit 0, next packet starts from flit 0
    rf_base = rf_count;
    push(PKT_A);
    push(PKT_B);
    check("t3 level", fifo_level, 2);
    for (int i = 0; i < 4; i++) flit("t3 f0 err", 16'h0123, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("t3 pulse width", rf_count - rf_base, 1);
    check("t3 level after drop", fifo_level, 1);
    flit("t3 b f0", 16'h0FED, 1'b0, 1'b0);
    flit("t3 b f1", 16'hCBA9, 1'b1, 1'b0);
    flit("t3 b f2", 16'h8765, 1'b0, 1'b0);
    flit("t3 b f3", 16'h4321, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("t3 level done", fifo_level, 0);

    // Backpressure: receiver silent, five packets offered
    push(PKT_A);
    push(PKT_B);
    push(PKT_A);
    push(PKT_B);
    pkt_data  = PKT_B;
    pkt_valid = 1'b1;
    @(negedge clk);
    check("t4 level full", fifo_level, 4);
    check("t4 pkt_ready", pkt_ready, 0);
    repeat (5) @(negedge clk);
    check("t4 held level", fifo_level, 4);
    check("t4 stall data", send_data_out, 16'h0123);
    flit("t4 f0", 16'h0123, 1'b0, 1'b0);
    flit("t4 f1", 16'h4567, 1'b0, 1'b0);
    flit("t4 f2", 16'h89AB, 1'b0, 1'b0);
    flit("t4 f3", 16'hCDEF, 1'b0, 1'b0);
    @(negedge clk);
    check("t4 still full", pkt_ready, 0);
    @(negedge clk);
    check("t4 slot free", pkt_ready, 1);
    check("t4 level popped", fifo_level, 3);
    @(negedge clk);
    pkt_valid = 1'b0;
    check("t4 fifth accepted", fifo_level, 4);
    check("t4 next head", send_data_out, 16'h0FED);
    do_reset();

    // Reset during flit 2 with two more packets buffered
    push(PKT_A);
    push(PKT_B);
    push(PKT_A);
    flit("t5 f0", 16'h0123, 1'b0, 1'b0);
    flit("t5 f1", 16'h4567, 1'b0, 1'b0);
    wait_valid("t5 f2");
    check("t5 f2 data", send_data_out, 16'h89AB);
    check("t5 level", fifo_level, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5 rst valid", send_data_valid, 0);
    check("t5 rst level", fifo_level, 0);
    check("t5 rst pkt_ready", pkt_ready, 1);
    check("t5 rst busy", busy, 0);
    check("t5 rst data", send_data_out, 0);
    repeat (4) @(negedge clk);
    check("t5 quiet", send_data_valid, 0);
    push(PKT_B);
    flit("t5 n f0", 16'h0FED, 1'b0, 1'b0);
    flit("t5 n f1", 16'hCBA9, 1'b1, 1'b0);
    flit("t5 n f2", 16'h8765, 1'b0, 1'b0);
    flit("t5 n f3", 16'h4321, 1'b1, 1'b0);

    // 32-bit packet, odd parity
    p32_data  = 32'h00010003;
    p32_valid = 1'b1;
    @(negedge clk);
    p32_valid = 1'b0;
    @(negedge clk);
    check("t6 f0 valid", s32_valid, 1);
    check("t6 f0 data", s32_out, 16'h0001);
    check("t6 f0 par", s32_par, 0);
    s32_ready = 1'b1;
    @(negedge clk);
    check("t6 f0 release", s32_valid, 0);
    s32_ready = 1'b0;
    for (int n = 0; n < 40 && s32_valid !== 1'b1; n++) @(negedge clk);
    check("t6 f1 valid", s32_valid, 1);
    check("t6 f1 data", s32_out, 16'h0003);
    check("t6 f1 par", s32_par, 1);
    s32_ready = 1'b1;
    @(negedge clk);
    s32_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("t6 busy done", busy32, 0);
    check("t6 level done", lvl32, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
